alu_frame_interface: RTL and testbench

ALU_FRAME_INTERFACE -- requirements
Module: alu_frame_interface

---
 rtl/alu_frame_pkg.sv | 25 ++
 rtl/alu_frame_if.sv | 13 +
 rtl/alu_frame_alu.sv | 29 ++
 rtl/alu_frame_interface.sv | 134 +++++++++++++
 tb/tb_alu_frame_interface.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_frame_pkg.sv
// Shared constants for the byte-framed ALU: FSM encodings, opcodes and a sizing helper.
package alu_frame_pkg;

  localparam logic [2:0] ST_A       = 3'd0;
  localparam logic [2:0] ST_B       = 3'd1;
  localparam logic [2:0] ST_OP      = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_TX_LOAD = 3'd4;
  localparam logic [2:0] ST_TX_WAIT = 3'd5;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // A byte index needs at least one bit even for single-byte operands.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_frame_if.sv
// Receive/transmit byte handshake between the framing block and its UART-style peers.
interface alu_frame_if #(
  parameter int NB_BYTE = 8
) ();
  logic               i_rx_done;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_tx_done;
  logic               o_tx_start;
  logic [NB_BYTE-1:0] o_tx_data;

  modport slave  (input  i_rx_done, i_rx_data, i_tx_done, output o_tx_start, o_tx_data);
  modport master (output i_rx_done, i_rx_data, i_tx_done, input  o_tx_start, o_tx_data);
endinterface

// File: rtl/alu_frame_alu.sv
// Combinational ALU; opcodes outside the supported set produce zero.
module alu
  import alu_frame_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int NB_CODE = 6
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_CODE-1:0] i_op,
  output logic [NB_DATA-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      NB_CODE'(OP_ADD): o_result = i_a + i_b;
      NB_CODE'(OP_SUB): o_result = i_a - i_b;
      NB_CODE'(OP_AND): o_result = i_a & i_b;
      NB_CODE'(OP_OR):  o_result = i_a | i_b;
      NB_CODE'(OP_XOR): o_result = i_a ^ i_b;
      NB_CODE'(OP_SRA): o_result = $signed(i_a) >>> i_b;
      NB_CODE'(OP_SRL): o_result = i_a >> i_b;
      NB_CODE'(OP_NOR): o_result = ~(i_a | i_b);
      default:          o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_frame_interface.sv
// Collects A, B and opcode bytes, runs the ALU, then streams the result back LSB first.
// Optional inter-byte abort of partial frames: define ALU_FRAME_TIMEOUT_EN.
module alu_frame_interface
  import alu_frame_pkg::*;
#(
  parameter int NB_BYTE        = 8,
  parameter int NB_DATA        = 16,
  parameter int NB_CODE        = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  alu_frame_if.slave         bus,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_result_valid,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int NBYTES = NB_DATA / NB_BYTE;
  localparam int IDX_W  = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  if ((NB_DATA % NB_BYTE) != 0 || NB_DATA < NB_BYTE || NB_CODE > NB_BYTE || TIMEOUT_CYCLES < 2)
  begin : g_bad_cfg
    $error("alu_frame_interface: illegal parameter combination");
  end

  logic [2:0]                      state;
  logic [IDX_W-1:0]                idx;
  logic [NBYTES-1:0][NB_BYTE-1:0]  a_q, b_q, res_bytes;
  logic [NB_CODE-1:0]              op_q;
  logic [NB_DATA-1:0]              alu_out;
  logic                            rx_acc;
  logic                            expire;

  assign rx_acc    = bus.i_rx_done && (state == ST_A || state == ST_B || state == ST_OP);
  assign res_bytes = o_result;
  assign o_busy    = !(state == ST_A && idx == '0);
  assign o_timeout = expire;

  alu #(.NB_DATA(NB_DATA), .NB_CODE(NB_CODE)) u_alu (
    .i_a      (a_q),
    .i_b      (b_q),
    .i_op     (op_q),
    .o_result (alu_out)
  );

`ifdef ALU_FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt;
  logic             counting;

  assign counting = state == ST_B || state == ST_OP || (state == ST_A && idx != '0);
  // A byte arriving in the expiry cycle takes precedence over the abort.
  assign expire   = counting && !bus.i_rx_done && cnt == CNT_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                          cnt <= '0;
    else if (rx_acc || !counting || expire) cnt <= '0;
    else                                    cnt <= cnt + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state          <= ST_A;
      idx            <= '0;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      bus.o_tx_start <= 1'b0;
      bus.o_tx_data  <= '0;
    end else begin
      o_result_valid <= 1'b0;
      bus.o_tx_start <= 1'b0;
      if (expire) begin
        state <= ST_A;
        idx   <= '0;
        a_q   <= '0;
        b_q   <= '0;
      end else begin
        case (state)
          ST_A: if (bus.i_rx_done) begin
            a_q[idx] <= bus.i_rx_data;
            if (idx == LAST) begin
              idx   <= '0;
              state <= ST_B;
            end else idx <= idx + 1'b1;
          end
          ST_B: if (bus.i_rx_done) begin
            b_q[idx] <= bus.i_rx_data;
            if (idx == LAST) begin
              idx   <= '0;
              state <= ST_OP;
            end else idx <= idx + 1'b1;
          end
          ST_OP: if (bus.i_rx_done) begin
            op_q  <= bus.i_rx_data[NB_CODE-1:0];
            state <= ST_EXEC;
          end
          ST_EXEC: begin
            o_result       <= alu_out;
            o_result_valid <= 1'b1;
            state          <= ST_TX_LOAD;
          end
          ST_TX_LOAD: begin
            bus.o_tx_data  <= res_bytes[idx];
            bus.o_tx_start <= 1'b1;
            state          <= ST_TX_WAIT;
          end
          ST_TX_WAIT: if (bus.i_tx_done) begin
            if (idx == LAST) begin
              idx   <= '0;
              state <= ST_A;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_TX_LOAD;
            end
          end
          default: begin
            state <= ST_A;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_frame_interface.sv
// Directed bench for alu_frame_interface (16-bit and 8-bit instances) with result/tx scoreboards.
module tb_alu_frame_interface;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_frame_if #(.NB_BYTE(8)) bus  ();
  alu_frame_if #(.NB_BYTE(8)) bus8 ();

  logic [15:0] result;
  logic        result_valid, busy, timeout;
  logic [7:0]  result8;
  logic        result_valid8, busy8, timeout8;

  alu_frame_interface #(.NB_BYTE(8), .NB_DATA(16), .NB_CODE(6), .TIMEOUT_CYCLES(16)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .bus(bus), .o_result(result),
    .o_result_valid(result_valid), .o_busy(busy), .o_timeout(timeout)
  );

  alu_frame_interface #(.NB_BYTE(8), .NB_DATA(8), .NB_CODE(6), .TIMEOUT_CYCLES(16)) u_dut8 (
    .i_clk(clk), .i_reset(rst_n), .bus(bus8), .o_result(result8),
    .o_result_valid(result_valid8), .o_busy(busy8), .o_timeout(timeout8)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_res_q [$];
  logic [7:0]  exp_tx_q  [$];

  logic [15:0] tab_a  [8] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h8421, 16'h8421, 16'h1234, 16'hFFFF};
  logic [15:0] tab_b  [8] = '{16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h0004, 16'h0004, 16'h1111, 16'h0002};
  logic [7:0]  tab_op [8] = '{8'h24,    8'h25,    8'h26,    8'h27,    8'h03,    8'h02,    8'h3F,    8'hE0};
  logic [15:0] tab_r  [8] = '{16'h3030, 16'hFCFC, 16'hCCCC, 16'h0303, 16'hF842, 16'h0842, 16'h0000, 16'h0001};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic send8(input logic [7:0] b);
    bus8.i_rx_data = b;
    bus8.i_rx_done = 1'b1;
    tick();
    bus8.i_rx_done = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] r);
    exp_res_q.push_back(r);
    exp_tx_q.push_back(r[7:0]);
    exp_tx_q.push_back(r[15:8]);
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                       input logic [15:0] r);
    push_exp(r);
    send(a[7:0]); send(a[15:8]); send(b[7:0]); send(b[15:8]); send(op);
  endtask

  // Called in the cycle right after the opcode byte was sampled.
  task automatic check_result();
    chk("valid_early", 32'(result_valid), 32'd0);
    tick();
    chk("valid", 32'(result_valid), 32'd1);
    chk("result", 32'(result), 32'(exp_res_q.pop_front()));
    tick();
    chk("valid_pulse", 32'(result_valid), 32'd0);
    chk("start_lat", 32'(bus.o_tx_start), 32'd1);
  endtask

  task automatic wait_start();
    int k = 0;
    while (!bus.o_tx_start && k < 10) begin
      tick();
      k++;
    end
    chk("tx_start_seen", 32'(bus.o_tx_start), 32'd1);
  endtask

  task automatic drain_tx(input int n, input bit inject);
    logic [7:0] held;
    for (int i = 0; i < n; i++) begin
      wait_start();
      held = bus.o_tx_data;
      chk("tx_data", 32'(held), 32'(exp_tx_q.pop_front()));
      tick();
      chk("tx_start_pulse", 32'(bus.o_tx_start), 32'd0);
      if (inject && i == 0) send(8'hAA);
      else tick();
      chk("tx_data_hold", 32'(bus.o_tx_data), 32'(held));
      chk("busy_tx", 32'(busy), 32'd1);
      bus.i_tx_done = 1'b1;
      tick();
      bus.i_tx_done = 1'b0;
    end
    chk("idle_after_tx", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    bus.i_rx_done  = 1'b0; bus.i_rx_data  = '0; bus.i_tx_done  = 1'b0;
    bus8.i_rx_done = 1'b0; bus8.i_rx_data = '0; bus8.i_tx_done = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_result",  32'(result),         32'd0);
    chk("rst_valid",   32'(result_valid),   32'd0);
    chk("rst_start",   32'(bus.o_tx_start), 32'd0);
    chk("rst_txdata",  32'(bus.o_tx_data),  32'd0);
    chk("rst_busy",    32'(busy),           32'd0);
    chk("rst_timeout", 32'(timeout),        32'd0);
    chk("rst_result8", 32'(result8),        32'd0);
    rst_n = 1'b1;
    tick();

    // Stray tx_done while idle must not disturb anything.
    bus.i_tx_done = 1'b1; tick(); bus.i_tx_done = 1'b0;
    chk("stray_txdone_busy",  32'(busy),           32'd0);
    chk("stray_txdone_start", 32'(bus.o_tx_start), 32'd0);

    frame(16'h1234, 16'h0101, 8'h20, 16'h1335); check_result(); drain_tx(2, 1'b0);
    frame(16'h0005, 16'h0007, 8'h22, 16'hFFFE); check_result(); drain_tx(2, 1'b0);

    for (int i = 0; i < 8; i++) begin
      frame(tab_a[i], tab_b[i], tab_op[i], tab_r[i]);
      check_result();
      drain_tx(2, 1'b0);
    end

    // Byte arriving during transmit is dropped; next frame starts at A byte 0.
    frame(16'h00FF, 16'h0F00, 8'h25, 16'h0FFF); check_result(); drain_tx(2, 1'b1);
    frame(16'h1234, 16'h0101, 8'h20, 16'h1335); check_result(); drain_tx(2, 1'b0);

    // Reset after the first transmitted byte abandons the second.
    frame(16'h0005, 16'h0007, 8'h22, 16'hFFFE); check_result();
    wait_start();
    chk("rst_mid_tx0", 32'(bus.o_tx_data), 32'(exp_tx_q.pop_front()));
    tick();
    bus.i_tx_done = 1'b1; tick(); bus.i_tx_done = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_result",  32'(result),         32'd0);
    chk("midrst_valid",   32'(result_valid),   32'd0);
    chk("midrst_start",   32'(bus.o_tx_start), 32'd0);
    chk("midrst_txdata",  32'(bus.o_tx_data),  32'd0);
    chk("midrst_busy",    32'(busy),           32'd0);
    chk("midrst_timeout", 32'(timeout),        32'd0);
    tick(); tick();
    rst_n = 1'b1;
    void'(exp_tx_q.pop_front());
    starts = 0;
    repeat (10) begin
      tick();
      if (bus.o_tx_start) starts++;
    end
    chk("no_start_after_rst", 32'(starts), 32'd0);

`ifdef ALU_FRAME_TIMEOUT_EN
    send(8'h34);
    for (int i = 0; i < 20; i++) begin
      chk("timeout_cycle", 32'(timeout), 32'(i == 15));
      tick();
    end
    chk("timeout_idle", 32'(busy), 32'd0);
    frame(16'h1234, 16'h0101, 8'h20, 16'h1335); check_result(); drain_tx(2, 1'b0);

    // A byte in the expiry cycle is accepted instead of aborting.
    send(8'h34);
    repeat (15) tick();
    chk("expiry_pending", 32'(timeout), 32'd1);
    bus.i_rx_data = 8'h12;
    bus.i_rx_done = 1'b1;
    #1;
    chk("expiry_rx_wins", 32'(timeout), 32'd0);
    @(posedge clk); #1;
    bus.i_rx_done = 1'b0;
    push_exp(16'h1335);
    send(8'h01); send(8'h01); send(8'h20);
    check_result(); drain_tx(2, 1'b0);
`else
    send(8'h34);
    repeat (20) begin
      chk("no_timeout", 32'(timeout), 32'd0);
      tick();
    end
    chk("partial_kept", 32'(busy), 32'd1);
    push_exp(16'h1335);
    send(8'h12); send(8'h01); send(8'h01); send(8'h20);
    check_result(); drain_tx(2, 1'b0);
`endif

    // Single-byte operands.
    exp_tx_q.push_back(8'hFF);
    send8(8'hF0); send8(8'h0F); send8(8'h25);
    chk("b8_valid_early", 32'(result_valid8), 32'd0);
    tick();
    chk("b8_valid",  32'(result_valid8), 32'd1);
    chk("b8_result", 32'(result8),       32'h0FF);
    tick();
    chk("b8_start",  32'(bus8.o_tx_start), 32'd1);
    chk("b8_txdata", 32'(bus8.o_tx_data),  32'(exp_tx_q.pop_front()));
    tick();
    bus8.i_tx_done = 1'b1; tick(); bus8.i_tx_done = 1'b0;
    chk("b8_idle", 32'(busy8), 32'd0);
    starts = 0;
    repeat (5) begin
      tick();
      if (bus8.o_tx_start) starts++;
    end
    chk("b8_single_start", 32'(starts), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
